adder_serial: RTL and testbench



---
 rtl/adder_serial_if.sv | 27 ++
 rtl/adder_serial.sv | 96 +++++++++
 tb/tb_adder_serial.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_serial_if.sv
// Operand/result handshake bundle for the digit-serial adder.
// The slave modport is the adder side, the master modport is the producer/consumer side.
interface adder_serial_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ovf;

   modport slave (
      input  in_valid, a, b, ci, sub, out_ready,
      output in_ready, out_valid, s, co, ovf
   );

   modport master (
      output in_valid, a, b, ci, sub, out_ready,
      input  in_ready, out_valid, s, co, ovf
   );
endinterface

// File: rtl/adder_serial.sv
// Digit-serial adder/subtractor: one DIGIT-bit carry chain reused over WIDTH/DIGIT cycles.
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | one digit per clock, result rotates into the A register
//   DONE  | result valid, held until the consumer takes it
module adder_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   adder_serial_if.slave  bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, s_q;
   logic [WIDTH-1:0] a_d, b_d;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, co_q, ovf_q, out_valid_q;

   logic [DIGIT-1:0] dig_a, dig_b, dig_s;
   logic             dig_c, msb_c, last, in_ready, accept;

   assign dig_a          = a_q[DIGIT-1:0];
   assign dig_b          = b_q[DIGIT-1:0];
   assign {dig_c, dig_s} = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};
   // Carry into the digit's top bit, recovered from the sum bit; only used on the last digit.
   assign msb_c          = dig_s[DIGIT-1] ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1];
   assign last           = (cnt_q == CW'(NDIG - 1));

   // The sum digit enters at the top of A while A shifts down; after NDIG steps A holds the result.
   if (NDIG == 1) begin : g_single
      assign a_d = dig_s;
      assign b_d = '0;
   end else begin : g_multi
      assign a_d = {dig_s, a_q[WIDTH-1:DIGIT]};
      assign b_d = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
   end

   assign in_ready      = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
   assign accept        = bus.in_valid && in_ready;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.s         = s_q;
   assign bus.co        = co_q;
   assign bus.ovf       = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         co_q        <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (state_q == DONE && bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
               if (accept) begin
                  a_q     <= bus.a;
                  b_q     <= bus.sub ? ~bus.b : bus.b;
                  carry_q <= bus.ci;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_d;
               b_q     <= b_d;
               carry_q <= dig_c;
               if (last) begin
                  s_q         <= a_d;
                  co_q        <= dig_c;
                  ovf_q       <= msb_c ^ dig_c;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adder_serial.sv
// Bench for adder_serial: directed table at DIGIT=8, multi-cycle corner sequences,
// and a random sweep over DIGIT in {1,4,32} against a reference model.
module tb_adder_serial;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sweep_go = 1'b0;
   int   n_checks = 0;
   int   n_fails = 0;

   always #5 clk = ~clk;

   adder_serial_if #(.WIDTH(32)) bus();
   adder_serial #(.WIDTH(32), .DIGIT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic        sub;
      logic [31:0] s;
      logic        co;
      logic        ovf;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Returns {s, co, ovf}; ovf from the carry into bit 31 computed on the low 31 bits.
   function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic ci, input logic sub);
      logic [31:0] bb;
      logic [32:0] full;
      logic [31:0] low;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {32'd0, ci};
      low  = {1'b0, a[30:0]} + {1'b0, bb[30:0]} + {31'd0, ci};
      return {full[31:0], full[32], low[31] ^ full[32]};
   endfunction

   task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = a; bus.b = b; bus.ci = ci; bus.sub = sub;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = $urandom; bus.b = $urandom; bus.ci = ~ci; bus.sub = ~sub;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int DG = (g == 0) ? 1 : ((g == 1) ? 4 : 32);
      logic done = 1'b0;
      adder_serial_if #(.WIDTH(32)) sbus();
      adder_serial #(.WIDTH(32), .DIGIT(DG)) u_dut (.clk(clk), .rst_n(rst_n), .bus(sbus));

      initial begin
         logic [31:0] ra, rb;
         logic        rci, rsub;
         int          lat;
         sbus.in_valid = 1'b0; sbus.out_ready = 1'b1;
         sbus.a = '0; sbus.b = '0; sbus.ci = 1'b0; sbus.sub = 1'b0;
         wait (sweep_go);
         for (int v = 0; v < 1000; v++) begin
            ra = $urandom; rb = $urandom; rci = 1'($urandom); rsub = 1'($urandom);
            @(negedge clk);
            sbus.in_valid = 1'b1;
            sbus.a = ra; sbus.b = rb; sbus.ci = rci; sbus.sub = rsub;
            @(posedge clk);
            #1;
            sbus.in_valid = 1'b0;
            sbus.a = ~ra; sbus.b = ~rb;
            lat = 0;
            for (int i = 1; i <= 40; i++) begin
               @(posedge clk);
               #1;
               if (sbus.out_valid) begin
                  lat = i;
                  break;
               end
            end
            chk($sformatf("sweep_d%0d_latency", DG), 64'(lat), 64'(32 / DG));
            chk($sformatf("sweep_d%0d_result a=%h b=%h ci=%b sub=%b", DG, ra, rb, rci, rsub),
                64'({sbus.s, sbus.co, sbus.ovf}), 64'(ref_add(ra, rb, rci, rsub)));
         end
         done = 1'b1;
      end
   end

   vec_t vecs[10];

   initial begin
      int lat;
      int hits;
      vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[1] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vecs[3] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
      vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
      vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
      vecs[6] = '{32'h00000001, 32'h00000001, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};
      vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
      vecs[8] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
      vecs[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};

      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.sub = 1'b0;

      #12;
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_result", 64'({bus.s, bus.co, bus.ovf}), 64'd0);
      chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         accept(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub);
         wait_result(lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
         chk($sformatf("vec%0d_result", i), 64'({bus.s, bus.co, bus.ovf}),
             64'({vecs[i].s, vecs[i].co, vecs[i].ovf}));
      end

      // Asynchronous reset while a result is held in DONE.
      bus.out_ready = 1'b0;
      accept(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
      wait_result(lat);
      chk("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midcycle_reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midcycle_reset_result", 64'({bus.s, bus.co, bus.ovf}), 64'd0);
      chk("midcycle_reset_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Backpressure: result and flags must hold while out_ready is low.
      accept(32'h00000005, 32'h00000007, 1'b1, 1'b1);
      wait_result(lat);
      chk("bp_latency", 64'(lat), 64'd4);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
         chk($sformatf("bp_hold%0d_in_ready", i), 64'(bus.in_ready), 64'd0);
         chk($sformatf("bp_hold%0d_result", i), 64'({bus.s, bus.co, bus.ovf}),
             64'({32'hFFFFFFFE, 1'b0, 1'b0}));
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.a = 32'h80000000; bus.b = 32'h00000001; bus.ci = 1'b1; bus.sub = 1'b1;
      #1;
      chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = $urandom; bus.b = $urandom;
      chk("bp_b2b_out_valid_drop", 64'(bus.out_valid), 64'd0);
      wait_result(lat);
      chk("bp_b2b_latency", 64'(lat), 64'd4);
      chk("bp_b2b_result", 64'({bus.s, bus.co, bus.ovf}), 64'({32'h7FFFFFFF, 1'b1, 1'b1}));

      // Reset in the second RUN cycle abandons the operation.
      accept(32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("run_reset_out_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) hits++;
      end
      chk("run_reset_no_pulse", 64'(hits), 64'd0);
      accept(32'h12345678, 32'h11111111, 1'b0, 1'b0);
      wait_result(lat);
      chk("after_reset_latency", 64'(lat), 64'd4);
      chk("after_reset_result", 64'({bus.s, bus.co, bus.ovf}), 64'({32'h23456789, 1'b0, 1'b0}));

      sweep_go = 1'b1;
      for (int i = 0; i < 60000; i++) begin
         if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) break;
         @(posedge clk);
      end
      chk("sweep_completed", 64'({g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}), 64'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
